// File: rtl/tea_frame_loader_if.sv
// UART byte handshake and CUT operand/result bus between the frame loader and its environment.
interface tea_frame_loader_if;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        cut_clk;
  logic        cut_nrst;
  logic [31:0] cut_v0_in;
  logic [31:0] cut_v1_in;
  logic [31:0] cut_k0;
  logic [31:0] cut_k1;
  logic [31:0] cut_k2;
  logic [31:0] cut_k3;
  logic [31:0] cut_v0_out;
  logic [31:0] cut_v1_out;
  logic        busy;

  // Loader side
  modport master (
    input  rx_data, rx_ready, tx_ready, cut_v0_out, cut_v1_out,
    output tx_start, tx_data, cut_clk, cut_nrst,
           cut_v0_in, cut_v1_in, cut_k0, cut_k1, cut_k2, cut_k3, busy
  );

  // UART / CUT side
  modport slave (
    output rx_data, rx_ready, tx_ready, cut_v0_out, cut_v1_out,
    input  tx_start, tx_data, cut_clk, cut_nrst,
           cut_v0_in, cut_v1_in, cut_k0, cut_k1, cut_k2, cut_k3, busy
  );
endinterface

// File: rtl/tea_frame_loader.sv
// Framed command front-end for the TEA tester: receives a 26-byte command,
// loads the CUT, sequences its reset/clock, captures the result and sends
// a 10-byte response (or a single 0xEE on checksum error).
module tea_frame_loader #(
  parameter int unsigned CUT_HALF   = 2,
  parameter int unsigned RUN_EDGES  = 33,
  parameter int unsigned RX_TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  tea_frame_loader_if.master bus
);

  localparam int unsigned HALF_W     = (CUT_HALF > 1) ? $clog2(CUT_HALF) : 1;
  localparam int unsigned EDGE_TOTAL = RUN_EDGES + 2;
  localparam int unsigned EDGE_W     = $clog2(EDGE_TOTAL + 1);
  localparam int unsigned TMO_W      = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;
  localparam int unsigned STAGE_W    = 192;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned IDX_W      = 4;

  typedef enum logic [2:0] {
    IDLE, RECV, CHECK, CUTRST, RUN, CAP, SEND, ERR
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic [7:0]           chk_q, chk_d;
  logic [STAGE_W-1:0]   stage_q, stage_d;
  logic [STAGE_W-1:0]   ops_q, ops_d;
  logic [TMO_W-1:0]     timer_q, timer_d;
  logic [HALF_W-1:0]    half_cnt_q, half_cnt_d;
  logic [EDGE_W-1:0]    edge_cnt_q, edge_cnt_d;
  logic [63:0]          result_q, result_d;
  logic [IDX_W-1:0]     tx_idx_q, tx_idx_d;
  logic                 tx_wait_q, tx_wait_d;
  logic                 tx_low_q, tx_low_d;
  logic                 tx_start_q, tx_start_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 cut_clk_q, cut_clk_d;
  logic                 cut_nrst_q, cut_nrst_d;
  logic                 busy_q, busy_d;

  logic                 half_end;
  logic [7:0]           tx_byte;
  logic [IDX_W-1:0]     tx_last;

  assign half_end = (half_cnt_q == HALF_W'(CUT_HALF - 1));
  assign tx_last  = (state_q == ERR) ? IDX_W'(0) : IDX_W'(9);

  // Byte to launch next: error code, or header / result bytes MSB first / status
  always_comb begin
    tx_byte = 8'h00;
    if (state_q == ERR) begin
      tx_byte = 8'hEE;
    end else begin
      case (tx_idx_q)
        4'd0:    tx_byte = 8'h5A;
        4'd1:    tx_byte = result_q[63:56];
        4'd2:    tx_byte = result_q[55:48];
        4'd3:    tx_byte = result_q[47:40];
        4'd4:    tx_byte = result_q[39:32];
        4'd5:    tx_byte = result_q[31:24];
        4'd6:    tx_byte = result_q[23:16];
        4'd7:    tx_byte = result_q[15:8];
        4'd8:    tx_byte = result_q[7:0];
        default: tx_byte = 8'h00;
      endcase
    end
  end

  // Next-state and datapath updates for the whole frame sequence
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    chk_d      = chk_q;
    stage_d    = stage_q;
    ops_d      = ops_q;
    timer_d    = timer_q;
    half_cnt_d = half_cnt_q;
    edge_cnt_d = edge_cnt_q;
    result_d   = result_q;
    tx_idx_d   = tx_idx_q;
    tx_wait_d  = tx_wait_q;
    tx_low_d   = tx_low_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    cut_clk_d  = cut_clk_q;
    cut_nrst_d = cut_nrst_q;

    case (state_q)
      IDLE: begin
        if (bus.rx_ready && (bus.rx_data == 8'hA5)) begin
          state_d    = RECV;
          byte_cnt_d = '0;
          chk_d      = '0;
          timer_d    = '0;
        end
      end

      RECV: begin
        if (bus.rx_ready) begin
          // CK is folded into the checksum too, so a good frame leaves zero
          timer_d    = '0;
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          chk_d      = chk_q ^ bus.rx_data;
          if (byte_cnt_q == CNT_W'(24)) begin
            state_d = CHECK;
          end else begin
            stage_d = {stage_q[STAGE_W-9:0], bus.rx_data};
          end
        end else if (timer_q == TMO_W'(RX_TIMEOUT - 1)) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TMO_W'(1);
        end
      end

      CHECK: begin
        if (chk_q == 8'h00) begin
          ops_d      = stage_q;
          cut_nrst_d = 1'b0;
          cut_clk_d  = 1'b0;
          half_cnt_d = '0;
          edge_cnt_d = '0;
          state_d    = CUTRST;
        end else begin
          tx_idx_d  = '0;
          tx_wait_d = 1'b0;
          tx_low_d  = 1'b0;
          state_d   = ERR;
        end
      end

      CUTRST, RUN: begin
        // edge_cnt counts every rising cut_clk edge, the reset ones included
        if (half_end) begin
          half_cnt_d = '0;
          if (cut_clk_q) begin
            cut_clk_d = 1'b0;
            if ((state_q == CUTRST) && (edge_cnt_q == EDGE_W'(2))) begin
              cut_nrst_d = 1'b1;
              state_d    = RUN;
            end
          end else if ((state_q == RUN) && (edge_cnt_q == EDGE_W'(EDGE_TOTAL))) begin
            state_d = CAP;
          end else begin
            cut_clk_d  = 1'b1;
            edge_cnt_d = edge_cnt_q + EDGE_W'(1);
          end
        end else begin
          half_cnt_d = half_cnt_q + HALF_W'(1);
        end
      end

      CAP: begin
        result_d  = {bus.cut_v0_out, bus.cut_v1_out};
        tx_idx_d  = '0;
        tx_wait_d = 1'b0;
        tx_low_d  = 1'b0;
        state_d   = SEND;
      end

      SEND, ERR: begin
        // Launch on tx_ready, then require ready low followed by high
        if (!tx_wait_q) begin
          if (bus.tx_ready) begin
            tx_start_d = 1'b1;
            tx_data_d  = tx_byte;
            tx_wait_d  = 1'b1;
            tx_low_d   = 1'b0;
          end
        end else if (!bus.tx_ready) begin
          tx_low_d = 1'b1;
        end else if (tx_low_q) begin
          tx_wait_d = 1'b0;
          if (tx_idx_q == tx_last) begin
            state_d = IDLE;
          end else begin
            tx_idx_d = tx_idx_q + IDX_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      chk_q      <= '0;
      stage_q    <= '0;
      ops_q      <= '0;
      timer_q    <= '0;
      half_cnt_q <= '0;
      edge_cnt_q <= '0;
      result_q   <= '0;
      tx_idx_q   <= '0;
      tx_wait_q  <= 1'b0;
      tx_low_q   <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      cut_clk_q  <= 1'b0;
      cut_nrst_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      chk_q      <= chk_d;
      stage_q    <= stage_d;
      ops_q      <= ops_d;
      timer_q    <= timer_d;
      half_cnt_q <= half_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      result_q   <= result_d;
      tx_idx_q   <= tx_idx_d;
      tx_wait_q  <= tx_wait_d;
      tx_low_q   <= tx_low_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      cut_clk_q  <= cut_clk_d;
      cut_nrst_q <= cut_nrst_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.cut_clk   = cut_clk_q;
  assign bus.cut_nrst  = cut_nrst_q;
  assign bus.cut_v0_in = ops_q[191:160];
  assign bus.cut_v1_in = ops_q[159:128];
  assign bus.cut_k0    = ops_q[127:96];
  assign bus.cut_k1    = ops_q[95:64];
  assign bus.cut_k2    = ops_q[63:32];
  assign bus.cut_k3    = ops_q[31:0];
  assign bus.busy      = busy_q;

endmodule
